// File: rtl/mul_div_if.sv
// Request/result bundle between the control sequencer and the multi-cycle
// multiply/divide engine.
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [4:0]           ALU_opcode;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2*WIDTH-1:0]   Z_out;
    logic                 busy;
    logic                 done;
    logic                 div_zero;

    modport master (
        output start, ALU_opcode, A, B,
        input  Z_out, busy, done, div_zero
    );

    modport slave (
        input  start, ALU_opcode, A, B,
        output Z_out, busy, done, div_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) and divide (restoring) engine
// producing the 64-bit {ZHI, ZLO} result for the datapath's Z register.
module mul_div_unit #(
    parameter int         WIDTH  = 32,
    parameter logic [4:0] MUL_OP = 5'b01110,
    parameter logic [4:0] DIV_OP = 5'b01111
) (
    input  logic     clk,
    input  logic     clr,
    mul_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t               state_reg;
    logic                 is_div_reg;
    logic                 dz_reg;
    logic                 a_neg_reg;
    logic                 b_neg_reg;
    logic [WIDTH-1:0]     m_reg;
    // acc_hi carries one guard bit so Booth's add/subtract of -2^(W-1) cannot wrap.
    logic [WIDTH:0]       acc_hi_reg;
    logic [WIDTH-1:0]     acc_lo_reg;
    logic                 acc_q_reg;
    logic [CW-1:0]        cnt_reg;
    logic [2*WIDTH-1:0]   z_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 div_zero_reg;

    logic                 accept;
    logic                 req_div;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       booth_sum;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH+1:0]     rem_diff;
    logic [WIDTH:0]       rem_next;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    always_comb begin
        req_div = (bus.ALU_opcode == DIV_OP);
        accept  = bus.start && ((bus.ALU_opcode == MUL_OP) || req_div);
        a_mag   = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
        b_mag   = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;

        booth_sum = acc_hi_reg;
        case ({acc_lo_reg[0], acc_q_reg})
            2'b01:   booth_sum = acc_hi_reg + {m_reg[WIDTH-1], m_reg};
            2'b10:   booth_sum = acc_hi_reg - {m_reg[WIDTH-1], m_reg};
            default: booth_sum = acc_hi_reg;
        endcase

        // Restoring step: shift next dividend bit in, keep the difference if non-negative.
        rem_shift = {acc_hi_reg[WIDTH-1:0], acc_lo_reg[WIDTH-1]};
        rem_diff  = {1'b0, rem_shift} - {2'b00, m_reg};
        rem_next  = rem_diff[WIDTH+1] ? rem_shift : rem_diff[WIDTH:0];

        quot_fix = (a_neg_reg ^ b_neg_reg) ? (~acc_lo_reg + 1'b1) : acc_lo_reg;
        rem_fix  = a_neg_reg ? (~acc_hi_reg[WIDTH-1:0] + 1'b1) : acc_hi_reg[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg    <= IDLE;
            is_div_reg   <= 1'b0;
            dz_reg       <= 1'b0;
            a_neg_reg    <= 1'b0;
            b_neg_reg    <= 1'b0;
            m_reg        <= '0;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= '0;
            acc_q_reg    <= 1'b0;
            cnt_reg      <= '0;
            z_reg        <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        is_div_reg   <= req_div;
                        a_neg_reg    <= bus.A[WIDTH-1];
                        b_neg_reg    <= bus.B[WIDTH-1];
                        cnt_reg      <= '0;
                        acc_q_reg    <= 1'b0;
                        div_zero_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        if (req_div) begin
                            acc_lo_reg <= a_mag;
                            m_reg      <= b_mag;
                            if (bus.B == '0) begin
                                // Raw dividend parked in acc_hi for the {A, all-ones} result.
                                dz_reg     <= 1'b1;
                                acc_hi_reg <= {bus.A[WIDTH-1], bus.A};
                                state_reg  <= FINISH;
                            end else begin
                                dz_reg     <= 1'b0;
                                acc_hi_reg <= '0;
                                state_reg  <= RUN;
                            end
                        end else begin
                            dz_reg     <= 1'b0;
                            acc_lo_reg <= bus.B;
                            m_reg      <= bus.A;
                            acc_hi_reg <= '0;
                            state_reg  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (is_div_reg) begin
                        acc_hi_reg <= rem_next;
                        acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], ~rem_diff[WIDTH+1]};
                    end else begin
                        {acc_hi_reg, acc_lo_reg, acc_q_reg} <= {booth_sum[WIDTH], booth_sum, acc_lo_reg};
                    end
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1))
                        state_reg <= FINISH;
                end
                FINISH: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    if (dz_reg) begin
                        z_reg        <= {acc_hi_reg[WIDTH-1:0], {WIDTH{1'b1}}};
                        div_zero_reg <= 1'b1;
                    end else if (is_div_reg) begin
                        z_reg <= {rem_fix, quot_fix};
                    end else begin
                        z_reg <= {acc_hi_reg[WIDTH-1:0], acc_lo_reg};
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.Z_out    = z_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.div_zero = div_zero_reg;
endmodule
